frame_buffer_writer: RTL and testbench



---
 rtl/frame_buffer_writer_if.sv | 28 ++
 rtl/frame_buffer_writer.sv | 213 +++++++++++++++++++++
 tb/tb_frame_buffer_writer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_writer_if.sv
// rtl/frame_buffer_writer_if.sv - stream, descriptor, read-port and free-handshake bundle for frame_buffer_writer
interface frame_buffer_writer_if #(
    parameter int AW = 12
);
    logic              sof;
    logic              dv;
    logic [7:0]        data;
    logic              desc_valid;
    logic [15+AW:0]    desc_dout;
    logic              desc_rd;
    logic [AW-1:0]     rd_addr;
    logic [7:0]        rd_data;
    logic              free_vld;
    logic [11:0]       free_len;
    logic              bp;
    logic [15:0]       frame_cnt;
    logic [15:0]       drop_cnt;

    modport master (
        output sof, dv, data, desc_rd, rd_addr, free_vld, free_len,
        input  desc_valid, desc_dout, rd_data, bp, frame_cnt, drop_cnt
    );

    modport slave (
        input  sof, dv, data, desc_rd, rd_addr, free_vld, free_len,
        output desc_valid, desc_dout, rd_data, bp, frame_cnt, drop_cnt
    );
endinterface

// File: rtl/frame_buffer_writer.sv
// rtl/frame_buffer_writer.sv - strips frame headers, buffers frame bytes in a circular buffer and queues descriptors
module frame_buffer_writer #(
    parameter int AW        = 12,
    parameter int DESC_AW   = 4,
    parameter int BP_THRESH = 2048
) (
    input  logic                 clk,
    input  logic                 rstn,
    frame_buffer_writer_if.slave bus
);
    localparam int              DW      = 16 + AW;
    localparam logic [AW:0]     DEPTH_V = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]     BP_T    = (AW+1)'(BP_THRESH);
    localparam logic [11:0]     CNT_MAX = 12'hFFF;

    typedef enum logic [1:0] {IDLE, HDR1, BODY, DROP} state_t;

    state_t state, state_n;

    // Byte buffer pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]    wr_ptr, fr_ptr, start;
    logic [AW:0]    used, free, rel, free_len_x;
    logic [AW:0]    wr_ptr_n, fr_ptr_n, free_n;
    logic [11:0]    cnt;
    logic [3:0]     portmap;
    logic [7:0]     mem [0:(1<<AW)-1];
    logic [7:0]     rd_data_q;
    logic           bp_q;
    logic [15:0]    frame_cnt_q, drop_cnt_q;

    // FSM control strobes.
    logic           hdr0, hdr1, wr_en, rollback, push;
    logic [1:0]     drop_inc;

    // Descriptor FIFO.
    logic [DW-1:0]      dmem [0:(1<<DESC_AW)-1];
    logic [DESC_AW:0]   dwp, drp;
    logic               d_empty, d_full, d_push, d_pop;

    assign d_empty = (dwp == drp);
    assign d_full  = (dwp[DESC_AW] != drp[DESC_AW]) &&
                     (dwp[DESC_AW-1:0] == drp[DESC_AW-1:0]);
    assign d_pop   = bus.desc_rd && !d_empty;
    assign d_push  = push && (!d_full || d_pop);

    // Occupancy, release amount and next-state pointers feeding bp.
    always_comb begin
        used       = wr_ptr - fr_ptr;
        free       = DEPTH_V - used;
        free_len_x = (AW+1)'(bus.free_len);
        rel        = '0;
        if (bus.free_vld) begin
            rel = (free_len_x < used) ? free_len_x : used;
        end
        wr_ptr_n = wr_ptr;
        if (rollback) begin
            wr_ptr_n = start;
        end else if (wr_en) begin
            wr_ptr_n = wr_ptr + 1'b1;
        end
        fr_ptr_n = fr_ptr + rel;
        free_n   = DEPTH_V - (wr_ptr_n - fr_ptr_n);
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and control strobes; the header length byte is consumed but not kept,
    // since the descriptor carries the measured byte count.
    always_comb begin
        state_n  = state;
        hdr0     = 1'b0;
        hdr1     = 1'b0;
        wr_en    = 1'b0;
        rollback = 1'b0;
        push     = 1'b0;
        drop_inc = 2'd0;
        case (state)
            IDLE: begin
                if (bus.dv && bus.sof) begin
                    hdr0 = 1'b1;
                    if (d_full) begin
                        drop_inc = 2'd1;
                        state_n  = DROP;
                    end else begin
                        state_n  = HDR1;
                    end
                end
            end
            HDR1: begin
                if (bus.dv) begin
                    hdr1    = 1'b1;
                    state_n = BODY;
                end else begin
                    state_n = IDLE;
                end
            end
            BODY: begin
                if (bus.dv && !bus.sof) begin
                    if (free == '0 || cnt == CNT_MAX) begin
                        rollback = 1'b1;
                        drop_inc = 2'd1;
                        state_n  = DROP;
                    end else begin
                        wr_en    = 1'b1;
                    end
                end else if (bus.dv && bus.sof) begin
                    // Aborted frame is discarded and this byte starts a new frame.
                    rollback = 1'b1;
                    hdr0     = 1'b1;
                    if (d_full) begin
                        drop_inc = 2'd2;
                        state_n  = DROP;
                    end else begin
                        drop_inc = 2'd1;
                        state_n  = HDR1;
                    end
                end else begin
                    push    = (cnt != 12'd0);
                    state_n = IDLE;
                end
            end
            DROP: begin
                if (!bus.dv) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pointers, frame bookkeeping, counters and backpressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            fr_ptr      <= '0;
            start       <= '0;
            cnt         <= '0;
            portmap     <= '0;
            bp_q        <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            fr_ptr <= fr_ptr_n;
            bp_q   <= (free_n < BP_T);
            if (hdr0) begin
                portmap <= bus.data[3:0];
            end
            if (hdr1) begin
                start <= wr_ptr;
                cnt   <= '0;
            end else if (wr_en) begin
                cnt   <= cnt + 12'd1;
            end
            if (push) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            drop_cnt_q <= drop_cnt_q + {14'd0, drop_inc};
        end
    end

    // Frame byte storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= bus.data;
        end
    end

    // Registered read port, independent of the write path.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[bus.rd_addr];
        end
    end

    // Descriptor FIFO storage.
    always_ff @(posedge clk) begin
        if (d_push) begin
            dmem[dwp[DESC_AW-1:0]] <= {portmap, cnt, start[AW-1:0]};
        end
    end

    // Descriptor FIFO pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dwp <= '0;
            drp <= '0;
        end else begin
            if (d_push) begin
                dwp <= dwp + 1'b1;
            end
            if (d_pop) begin
                drp <= drp + 1'b1;
            end
        end
    end

    assign bus.desc_valid = !d_empty;
    assign bus.desc_dout  = d_empty ? '0 : dmem[drp[DESC_AW-1:0]];
    assign bus.rd_data    = rd_data_q;
    assign bus.bp         = bp_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb/tb_frame_buffer_writer.sv - directed self-checking bench for frame_buffer_writer
module tb_frame_buffer_writer;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    frame_buffer_writer_if #(.AW(AW)) bus ();

    frame_buffer_writer #(.AW(AW), .DESC_AW(4), .BP_THRESH(2048)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        bus.sof      = 1'b0;
        bus.dv       = 1'b0;
        bus.data     = 8'h00;
        bus.desc_rd  = 1'b0;
        bus.rd_addr  = '0;
        bus.free_vld = 1'b0;
        bus.free_len = 12'd0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.sof = 1'b0;
            bus.dv  = 1'b0;
        end
    endtask

    task automatic hdr(input logic [3:0] pm, input logic [11:0] len);
        @(negedge clk);
        bus.sof  = 1'b1;
        bus.dv   = 1'b1;
        bus.data = {len[11:8], pm};
        @(negedge clk);
        bus.sof  = 1'b0;
        bus.data = len[7:0];
    endtask

    task automatic body(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sof  = 1'b0;
            bus.dv   = 1'b1;
            bus.data = base + 8'(i);
        end
    endtask

    task automatic frame(input logic [3:0] pm, input int n, input logic [7:0] base);
        hdr(pm, 12'(n));
        body(n, base);
        idle(2);
    endtask

    task automatic pop();
        @(negedge clk);
        bus.desc_rd = 1'b1;
        @(negedge clk);
        bus.desc_rd = 1'b0;
    endtask

    task automatic release_bytes(input logic [11:0] n);
        @(negedge clk);
        bus.free_vld = 1'b1;
        bus.free_len = n;
        @(negedge clk);
        bus.free_vld = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] a, input logic [7:0] exp);
        @(negedge clk);
        bus.rd_addr = a;
        @(negedge clk);
        check(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_desc_valid", 32'(bus.desc_valid), 32'd0);
        check("rst_desc_dout",  32'(bus.desc_dout),  32'd0);
        check("rst_rd_data",    32'(bus.rd_data),    32'd0);
        check("rst_bp",         32'(bus.bp),         32'd0);
        check("rst_frame_cnt",  32'(bus.frame_cnt),  32'd0);
        check("rst_drop_cnt",   32'(bus.drop_cnt),   32'd0);

        // Single 64-byte frame
        frame(4'h1, 64, 8'h00);
        check("t1_valid", 32'(bus.desc_valid), 32'd1);
        check("t1_desc",  32'(bus.desc_dout),  32'({4'h1, 12'd64, 12'h000}));
        check("t1_fcnt",  32'(bus.frame_cnt),  32'd1);
        check("t1_bp",    32'(bus.bp),         32'd0);
        rd_check("t1_rd5", 12'h005, 8'h05);

        // Back-to-back frames with one idle cycle
        do_reset();
        hdr(4'h2, 12'd100);
        body(100, 8'h00);
        idle(1);
        hdr(4'h8, 12'd60);
        body(60, 8'h80);
        idle(2);
        check("t2_desc0", 32'(bus.desc_dout), 32'({4'h2, 12'd100, 12'h000}));
        pop();
        check("t2_valid1", 32'(bus.desc_valid), 32'd1);
        check("t2_desc1", 32'(bus.desc_dout), 32'({4'h8, 12'd60, 12'h064}));
        pop();
        check("t2_empty", 32'(bus.desc_valid), 32'd0);
        check("t2_fcnt",  32'(bus.frame_cnt),  32'd2);
        rd_check("t2_rd64", 12'h064, 8'h80);

        // Wrap-around
        do_reset();
        frame(4'h4, 4080, 8'h00);
        check("t3_bp_full", 32'(bus.bp), 32'd1);
        check("t3_desc0", 32'(bus.desc_dout), 32'({4'h4, 12'hFF0, 12'h000}));
        pop();
        release_bytes(12'hFF0);
        check("t3_bp_freed", 32'(bus.bp), 32'd0);
        frame(4'h5, 32, 8'h00);
        check("t3_desc1", 32'(bus.desc_dout), 32'({4'h5, 12'd32, 12'hFF0}));
        check("t3_free", 32'(dut.free), 32'd4064);
        rd_check("t3_rd000", 12'h000, 8'h10);
        rd_check("t3_rd00f", 12'h00F, 8'h1F);
        rd_check("t3_rdff0", 12'hFF0, 8'h00);
        rd_check("t3_rdfef", 12'hFEF, 8'hEF);

        // Overflow drop and rollback
        do_reset();
        frame(4'h6, 4086, 8'h00);
        frame(4'h7, 20, 8'h40);
        check("t4_drop",  32'(bus.drop_cnt),  32'd1);
        check("t4_fcnt1", 32'(bus.frame_cnt), 32'd1);
        check("t4_wrptr", 32'(dut.wr_ptr),    32'd4086);
        frame(4'h9, 8, 8'hC0);
        check("t4_fcnt2", 32'(bus.frame_cnt), 32'd2);
        check("t4_desc0", 32'(bus.desc_dout), 32'({4'h6, 12'hFF6, 12'h000}));
        pop();
        check("t4_desc1", 32'(bus.desc_dout), 32'({4'h9, 12'd8, 12'hFF6}));
        rd_check("t4_rdff6", 12'hFF6, 8'hC0);

        // Descriptor FIFO full
        do_reset();
        for (int i = 0; i < 16; i++) begin
            frame(4'(i), 4, 8'(i * 4));
        end
        check("t5_fcnt16", 32'(bus.frame_cnt), 32'd16);
        check("t5_head",   32'(bus.desc_dout), 32'({4'h0, 12'd4, 12'h000}));
        frame(4'hE, 4, 8'hEE);
        check("t5_drop",    32'(bus.drop_cnt),  32'd1);
        check("t5_fcnt_nc", 32'(bus.frame_cnt), 32'd16);
        pop();
        frame(4'hA, 4, 8'h50);
        check("t5_fcnt17", 32'(bus.frame_cnt), 32'd17);
        check("t5_drop_nc", 32'(bus.drop_cnt), 32'd1);
        for (int i = 0; i < 15; i++) begin
            pop();
        end
        check("t5_desc18", 32'(bus.desc_dout), 32'({4'hA, 12'd4, 12'h040}));
        rd_check("t5_rd040", 12'h040, 8'h50);

        // Runts
        do_reset();
        @(negedge clk);
        bus.sof  = 1'b1;
        bus.dv   = 1'b1;
        bus.data = 8'h01;
        idle(2);
        hdr(4'h3, 12'h005);
        idle(2);
        check("t6_valid", 32'(bus.desc_valid), 32'd0);
        check("t6_fcnt",  32'(bus.frame_cnt),  32'd0);
        check("t6_drop",  32'(bus.drop_cnt),   32'd0);
        frame(4'h3, 5, 8'h30);
        check("t6_after", 32'(bus.desc_dout), 32'({4'h3, 12'd5, 12'h000}));

        // sof during body
        do_reset();
        hdr(4'h3, 12'd10);
        body(10, 8'h10);
        hdr(4'h5, 12'd6);
        body(6, 8'hA0);
        idle(2);
        check("t7_drop", 32'(bus.drop_cnt),  32'd1);
        check("t7_fcnt", 32'(bus.frame_cnt), 32'd1);
        check("t7_desc", 32'(bus.desc_dout), 32'({4'h5, 12'd6, 12'h000}));
        rd_check("t7_rd0", 12'h000, 8'hA0);
        rd_check("t7_rd5", 12'h005, 8'hA5);

        // Backpressure threshold
        do_reset();
        frame(4'h1, 2048, 8'h00);
        check("t8_bp2048", 32'(bus.bp), 32'd0);
        frame(4'h1, 1, 8'h00);
        check("t8_bp2049", 32'(bus.bp), 32'd1);
        release_bytes(12'd2);
        check("t8_bp_rel", 32'(bus.bp), 32'd0);

        // Reset mid-body
        do_reset();
        frame(4'h2, 8, 8'h11);
        rd_check("t9_rd0", 12'h000, 8'h11);
        hdr(4'h4, 12'd20);
        body(5, 8'h20);
        #2;
        rstn = 1'b0;
        #1;
        check("t9_valid", 32'(bus.desc_valid), 32'd0);
        check("t9_dout",  32'(bus.desc_dout),  32'd0);
        check("t9_rd",    32'(bus.rd_data),    32'd0);
        check("t9_fcnt",  32'(bus.frame_cnt),  32'd0);
        check("t9_drop",  32'(bus.drop_cnt),   32'd0);
        check("t9_bp",    32'(bus.bp),         32'd0);
        do_reset();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
